// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: next-PC select encoding,
// controller state encoding and the instruction RAM read latency.
package fetch_sequencer_pkg;

  // Next-PC source driven to the fetch datapath mux.
  typedef enum logic [1:0] {
    PcHold    = 2'd0,
    PcInc     = 2'd1,
    PcBranch  = 2'd2,
    PcRestart = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StMem   = 2'd2,
    StFlush = 2'd3
  } state_e;

  // Instruction RAM read latency in cycles; the return tracking is one flop deep.
  localparam int unsigned RamLatency = 1;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: controller for the instruction-fetch datapath. It decides each
// cycle whether the shared RAM serves an instruction fetch or an exec load/store,
// tracks the one-cycle fetch return, steers the next-PC mux and flushes the FIFO
// on an exec redirect.
//
// Ports:
//   clk                 rising-edge clock
//   reset_i             asynchronous active-high reset
//   restart_i           exec redirect (restart address held in the datapath)
//   load_store_valid_i  exec requests a RAM data access
//   store_en_i          qualifies the access as a store
//   p_bit_i             predict-taken bit of the returning instruction
//   fifo_full_i         FIFO full (one skid entry still free)
//   fifo_valid_i        FIFO head valid
//   pc_sel_o            next-PC source (HOLD/INC/BRANCH/RESTART)
//   ram_src_o           RAM address source: 0 PC path, 1 load/store address
//   ram_we_o            RAM write enable
//   fifo_enqueue_o      enqueue the returning instruction/address
//   fifo_clear_o        flush the FIFO
//   load_data_valid_o   RAM read data is load data this cycle
//   instruction_valid_o head instruction valid to exec
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       restart_i,
  input  logic       load_store_valid_i,
  input  logic       store_en_i,
  input  logic       p_bit_i,
  input  logic       fifo_full_i,
  input  logic       fifo_valid_i,
  output logic [1:0] pc_sel_o,
  output logic       ram_src_o,
  output logic       ram_we_o,
  output logic       fifo_enqueue_o,
  output logic       fifo_clear_o,
  output logic       load_data_valid_o,
  output logic       instruction_valid_o
);

  // Return tracking below is a single flop; a deeper RAM needs a pipeline here.
  if (RamLatency != 1) begin : gen_latency_check
    $error("fetch_sequencer supports a RAM read latency of exactly one cycle");
  end

  state_e  state_q, state_d;
  logic    ret_v_r, ret_v_d;
  logic    store_q, store_d;
  logic    load_pend_q, load_pend_d;
  logic    issue;
  logic    clear;
  pc_sel_e pc_sel;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      ret_v_r     <= 1'b0;
      store_q     <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_v_r     <= ret_v_d;
      store_q     <= store_d;
      load_pend_q <= load_pend_d;
    end
  end

  // Priority in every state: restart > load/store > fetch.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    load_pend_d = 1'b0;
    issue       = 1'b0;
    clear       = 1'b0;
    pc_sel      = PcHold;
    unique case (state_q)
      StIdle: begin
        if (restart_i) begin
          clear   = 1'b1;
          state_d = StFlush;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (restart_i) begin
          clear   = 1'b1;
          state_d = StFlush;
        end else if (load_store_valid_i) begin
          store_d = store_en_i;
          state_d = StMem;
        end else if (!fifo_full_i) begin
          issue  = 1'b1;
          // A predicted-taken return redirects this very fetch to its target.
          pc_sel = (ret_v_r && p_bit_i) ? PcBranch : PcInc;
        end
      end
      StMem: begin
        // The write itself completes regardless; a restart only drops load data.
        load_pend_d = !store_q && !restart_i;
        if (restart_i) begin
          clear   = 1'b1;
          state_d = StFlush;
        end else begin
          state_d = StFetch;
        end
      end
      StFlush: begin
        // Nothing can be returning here (the restart cycle issued no fetch), so
        // keeping the clear asserted is harmless and covers the whole redirect.
        clear = 1'b1;
        if (restart_i) begin
          state_d = StFlush;
        end else begin
          issue   = 1'b1;
          pc_sel  = PcRestart;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fetch never issues alongside a restart, so the only return that needs
  // squashing is the one arriving in the restart cycle itself.
  assign ret_v_d             = issue;
  assign fifo_enqueue_o      = ret_v_r && !restart_i;
  assign fifo_clear_o        = clear;
  assign pc_sel_o            = pc_sel;
  assign ram_src_o           = (state_q == StMem);
  assign ram_we_o            = (state_q == StMem) && store_q;
  assign load_data_valid_o   = load_pend_q;
  assign instruction_valid_o = fifo_valid_i && !restart_i && !clear;

endmodule
